// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU-side request/response signals and memory-controller pins
// for the shared 16-bit memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [15:0]           if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic                  d_wide;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  // Core and memory controller side.
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_wide, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_rd_en, mem_wr_en, mem_en, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_wide, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_rd_en, mem_wr_en, mem_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit synchronous memory port between
// instruction fetch and load/store, splitting 32-bit accesses into two beats.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, WIDE2} state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  // Read-return tag: one entry per issued memory read command.
  typedef struct packed {
    logic valid;
    logic is_d;
    logic wide;
    logic beat;
  } tag_t;

  state_t                state_q, state_d;
  port_t                 last_q, last_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           whi_q, whi_d;
  logic [15:0]           low_q, low_d;
  tag_t                  tag0_q, tag0_d;
  tag_t                  tag1_q;

  logic                  grant_if;
  logic                  grant_d;
  logic                  if_deliver;
  logic                  d_deliver;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    whi_d    = whi_q;
    tag0_d   = '0;
    grant_if = 1'b0;
    grant_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!reset) begin
          if (bus.if_req && (!bus.d_req || last_q == PORT_D)) begin
            grant_if = 1'b1;
          end else if (bus.d_req) begin
            grant_d = 1'b1;
          end
        end

        if (grant_if) begin
          last_d       = PORT_IF;
          rd_en_d      = 1'b1;
          addr_d       = bus.if_addr;
          tag0_d.valid = 1'b1;
          tag0_d.is_d  = 1'b0;
        end else if (grant_d) begin
          last_d       = PORT_D;
          rd_en_d      = !bus.d_we;
          wr_en_d      = bus.d_we;
          addr_d       = bus.d_addr;
          whi_d        = bus.d_wdata[31:16];
          if (bus.d_we) begin
            wdata_d = bus.d_wdata[15:0];
          end
          tag0_d.valid = !bus.d_we;
          tag0_d.is_d  = 1'b1;
          tag0_d.wide  = bus.d_wide;
          if (bus.d_wide) begin
            state_d = WIDE2;
          end
        end
      end

      WIDE2: begin
        // Beat 2 reuses the beat-1 command, so the requester may drop its payload after grant.
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        if (wr_en_q) begin
          wdata_d = whi_q;
        end
        tag0_d      = tag0_q;
        tag0_d.beat = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign if_deliver = tag1_q.valid && !tag1_q.is_d;
  assign d_deliver  = tag1_q.valid && tag1_q.is_d && (!tag1_q.wide || tag1_q.beat);

  always_comb begin
    low_d = low_q;
    if (tag1_q.valid && tag1_q.is_d && tag1_q.wide && !tag1_q.beat) begin
      low_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= PORT_D;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      whi_q   <= '0;
      low_q   <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      whi_q   <= whi_d;
      low_q   <= low_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag0_q;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_en    = rd_en_q | wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_rvalid = if_deliver;
  assign bus.if_rdata  = if_deliver ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = d_deliver;
  assign bus.d_rdata   = !d_deliver  ? '0 :
                         tag1_q.wide ? {bus.mem_rdata, low_q} :
                                       {16'h0000, bus.mem_rdata};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_WIDTH(12)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous memory: read data appears the cycle after the command.
  logic [15:0] mem [0:4095];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic        wide;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_wide  = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    a = 12'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = a | 12'hFF0;
    return a;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic rd;
    logic [11:0] a2;
    rd = !v.is_d || !v.we;
    a2 = 12'(v.addr + 12'd1);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_wide = v.wide;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    @(negedge clock);
    chk($sformatf("vec%0d_if_gnt", idx), 32'(bus.if_gnt), 32'(!v.is_d));
    chk($sformatf("vec%0d_d_gnt", idx), 32'(bus.d_gnt), 32'(v.is_d));
    tick(); idle_inputs();
    @(negedge clock);
    chk($sformatf("vec%0d_b1_rd", idx), 32'(bus.mem_rd_en), 32'(rd));
    chk($sformatf("vec%0d_b1_wr", idx), 32'(bus.mem_wr_en), 32'(!rd));
    chk($sformatf("vec%0d_b1_addr", idx), 32'(bus.mem_addr), 32'(v.addr));
    if (!rd) chk($sformatf("vec%0d_b1_wdata", idx), 32'(bus.mem_wdata), 32'(v.wdata[15:0]));
    tick();
    @(negedge clock);
    if (v.is_d && v.wide) begin
      chk($sformatf("vec%0d_b2_rd", idx), 32'(bus.mem_rd_en), 32'(rd));
      chk($sformatf("vec%0d_b2_wr", idx), 32'(bus.mem_wr_en), 32'(!rd));
      chk($sformatf("vec%0d_b2_addr", idx), 32'(bus.mem_addr), 32'(a2));
      if (!rd) chk($sformatf("vec%0d_b2_wdata", idx), 32'(bus.mem_wdata), 32'(v.wdata[31:16]));
      chk($sformatf("vec%0d_early_rvalid", idx), 32'(bus.d_rvalid), 32'd0);
      tick();
      @(negedge clock);
      chk($sformatf("vec%0d_d_rvalid", idx), 32'(bus.d_rvalid), 32'(rd));
      if (rd) chk($sformatf("vec%0d_d_rdata", idx), bus.d_rdata, v.exp);
    end else begin
      chk($sformatf("vec%0d_mem_en_off", idx), 32'(bus.mem_en), 32'd0);
      chk($sformatf("vec%0d_if_rvalid", idx), 32'(bus.if_rvalid), 32'(!v.is_d));
      chk($sformatf("vec%0d_d_rvalid", idx), 32'(bus.d_rvalid), 32'(v.is_d && !v.we));
      if (!v.is_d) chk($sformatf("vec%0d_if_rdata", idx), 32'(bus.if_rdata), 32'(v.exp[15:0]));
      else if (!v.we) chk($sformatf("vec%0d_d_rdata", idx), bus.d_rdata, v.exp);
    end
    tick();
    @(negedge clock);
    chk($sformatf("vec%0d_no_extra_rv", idx), 32'(bus.if_rvalid | bus.d_rvalid), 32'd0);
    tick();
  endtask

  vec_t vecs[10];
  rsp_t q[$];

  initial begin
    logic        exp_f;
    logic        pf, pd, gf, gd, ef, ed, last_is_d, dwe, dwide;
    logic [11:0] fa, da;
    logic [31:0] dwd;
    logic [15:0] ref_mem [0:4095];
    rsp_t        r;
    int          next_free;

    //            is_d  we    wide  addr     wdata          exp
    vecs[0] = '{1'b1, 1'b1, 1'b0, 12'h010, 32'h0000BEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 12'h010, 32'h0,        32'h0000BEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 12'hFFF, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        32'h00001234};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 12'hFFF, 32'h0,        32'h00005678};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 12'h055, 32'hAAAACAFE, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 12'h056, 32'h00007777, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 12'h055, 32'h0,        32'h7777CAFE};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 12'h055, 32'h0,        32'h0000CAFE};

    // Reset state, with requests asserted to show grants are held off.
    idle_inputs();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    #1;
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rvalids", 32'(bus.if_rvalid | bus.d_rvalid), 32'd0);
    chk("rst_rdata", {bus.if_rdata, 16'h0} | bus.d_rdata, 32'd0);
    idle_inputs();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Tie in the first cycle after reset goes to fetch, then strict alternation.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    bus.d_req = 1'b1; bus.d_addr = 12'h020;
    @(negedge clock);
    chk("tie0_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("tie0_d_gnt", 32'(bus.d_gnt), 32'd0);
    tick(); bus.if_req = 1'b0;
    @(negedge clock);
    chk("tie1_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("tie1_mem_addr", 32'(bus.mem_addr), 32'h010);
    chk("tie1_mem_rd", 32'(bus.mem_rd_en), 32'd1);
    tick(); bus.if_req = 1'b1;
    exp_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("alt%0d_if_gnt", i), 32'(bus.if_gnt), 32'(exp_f));
      chk($sformatf("alt%0d_d_gnt", i), 32'(bus.d_gnt), 32'(!exp_f));
      exp_f = !exp_f;
      tick();
    end
    idle_inputs(); repeat (4) tick();

    // Fetch held through a wide write is blocked in the second beat.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wide = 1'b1;
    bus.d_addr = 12'h200; bus.d_wdata = 32'hA5A55A5A;
    @(negedge clock);
    chk("ww_d_gnt", 32'(bus.d_gnt), 32'd1);
    tick(); idle_inputs(); bus.if_req = 1'b1; bus.if_addr = 12'h200;
    @(negedge clock);
    chk("ww_if_blocked", 32'(bus.if_gnt), 32'd0);
    tick();
    @(negedge clock);
    chk("ww_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("ww_b2_addr", 32'(bus.mem_addr), 32'h201);
    chk("ww_b2_wdata", 32'(bus.mem_wdata), 32'hA5A5);
    tick(); idle_inputs();
    tick();
    @(negedge clock);
    chk("ww_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("ww_if_rdata", 32'(bus.if_rdata), 32'h5A5A);
    tick(); repeat (3) tick();

    // Preload via back-to-back narrow writes, then four back-to-back fetches.
    for (int k = 0; k < 4; k++) begin
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'(12'h100 + k);
      bus.d_wdata = 32'(32'h1100 + k);
      @(negedge clock);
      chk($sformatf("pre%0d_d_gnt", k), 32'(bus.d_gnt), 32'd1);
      tick();
    end
    idle_inputs(); repeat (3) tick();
    for (int c = 0; c < 6; c++) begin
      bus.if_req = (c < 4);
      bus.if_addr = 12'(12'h100 + c);
      @(negedge clock);
      if (c < 4) chk($sformatf("b2b%0d_if_gnt", c), 32'(bus.if_gnt), 32'd1);
      chk($sformatf("b2b%0d_if_rvalid", c), 32'(bus.if_rvalid), 32'(c >= 2));
      if (c >= 2) chk($sformatf("b2b%0d_if_rdata", c), 32'(bus.if_rdata), 32'(32'h1100 + c - 2));
      tick();
    end
    idle_inputs(); repeat (3) tick();

    // Reset in the second beat of a wide read while a fetch return is due.
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    @(negedge clock);
    chk("mr_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick(); idle_inputs();
    bus.d_req = 1'b1; bus.d_wide = 1'b1; bus.d_addr = 12'h055;
    @(negedge clock);
    chk("mr_d_gnt", 32'(bus.d_gnt), 32'd1);
    tick(); idle_inputs();
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    reset = 1'b1;
    #1;
    chk("mr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("mr_if_rdata", 32'(bus.if_rdata), 32'd0);
    chk("mr_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mr_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mr_gnts", 32'(bus.if_gnt | bus.d_gnt), 32'd0);
    idle_inputs();
    tick(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("mr_quiet%0d", c), 32'(bus.if_rvalid | bus.d_rvalid | bus.mem_en), 32'd0);
      tick();
    end
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    @(negedge clock);
    chk("mr_tie_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("mr_tie_d_gnt", 32'(bus.d_gnt), 32'd0);
    tick(); idle_inputs(); repeat (4) tick();

    // Randomized traffic against a transaction-level model.
    mem_clr = 1'b1; reset = 1'b1; tick(); mem_clr = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    last_is_d = 1'b1; next_free = 0; pf = 1'b0; pd = 1'b0;
    fa = '0; da = '0; dwe = 1'b0; dwide = 1'b0; dwd = '0;
    for (int c = 0; c < 410; c++) begin
      if (c < 400 && !pf && $urandom_range(0, 2) != 0) begin
        pf = 1'b1; fa = rand_addr();
      end
      if (c < 400 && !pd && $urandom_range(0, 2) != 0) begin
        pd = 1'b1; da = rand_addr(); dwe = 1'($urandom_range(0, 1));
        dwide = 1'($urandom_range(0, 1)); dwd = $urandom;
      end
      bus.if_req = pf; bus.if_addr = fa;
      bus.d_req = pd; bus.d_we = dwe; bus.d_wide = dwide; bus.d_addr = da; bus.d_wdata = dwd;
      @(negedge clock);
      ef = 1'b0; ed = 1'b0; r = '{0, 1'b0, 32'h0};
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        ef = !r.is_d; ed = r.is_d;
      end
      chk($sformatf("rnd%0d_if_rvalid", c), 32'(bus.if_rvalid), 32'(ef));
      chk($sformatf("rnd%0d_d_rvalid", c), 32'(bus.d_rvalid), 32'(ed));
      if (ef) chk($sformatf("rnd%0d_if_rdata", c), 32'(bus.if_rdata), r.data);
      if (ed) chk($sformatf("rnd%0d_d_rdata", c), bus.d_rdata, r.data);
      gf = 1'b0; gd = 1'b0;
      if (c >= next_free) begin
        if (pf && pd) begin gf = last_is_d; gd = !last_is_d; end
        else begin gf = pf; gd = pd; end
      end
      chk($sformatf("rnd%0d_if_gnt", c), 32'(bus.if_gnt), 32'(gf));
      chk($sformatf("rnd%0d_d_gnt", c), 32'(bus.d_gnt), 32'(gd));
      if (gf) begin
        last_is_d = 1'b0; next_free = c + 1; pf = 1'b0;
        q.push_back('{c + 2, 1'b0, {16'h0000, ref_mem[fa]}});
      end
      if (gd) begin
        last_is_d = 1'b1; next_free = c + (dwide ? 2 : 1); pd = 1'b0;
        if (dwe) begin
          ref_mem[da] = dwd[15:0];
          if (dwide) ref_mem[12'(da + 12'd1)] = dwd[31:16];
        end else if (dwide) begin
          q.push_back('{c + 3, 1'b1, {ref_mem[12'(da + 12'd1)], ref_mem[da]}});
        end else begin
          q.push_back('{c + 2, 1'b1, {16'h0000, ref_mem[da]}});
        end
      end
      tick();
    end
    chk("rnd_queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 16-bit synchronous memory port (4096 words, 12-bit word address) between the CPU instruction-fetch unit and the load/store unit. Arbitrates round-robin, registers the memory command, splits 32-bit data accesses into two 16-bit beats, and returns read data to the correct requester. Sits between the CPU core and the memory controller's `to_mem`/`from_mem` pins.

## Interface
- `ADDR_WIDTH`, 12, memory word-address width; wraps modulo 2^ADDR_WIDTH.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  fetch word address.
- `if_gnt`  out  1  one-cycle grant to fetch.
- `if_rvalid`  out  1  one-cycle fetch data valid.
- `if_rdata`  out  16  fetch data.
- `d_req`  in  1  data request; held with payload until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_wide`  in  1  1 = 32-bit (two beats), 0 = 16-bit.
- `d_addr`  in  ADDR_WIDTH  data word address (low half for wide).
- `d_wdata`  in  32  write data; `[15:0]` narrow/low, `[31:16]` high.
- `d_gnt`  out  1  one-cycle grant to data port.
- `d_rvalid`  out  1  one-cycle data-read valid.
- `d_rdata`  out  32  read data; `[31:16]` zero for narrow reads.
- `mem_rd_en`, `mem_wr_en`, `mem_en`  out  1 each  registered memory strobes; `mem_en = mem_rd_en | mem_wr_en`.
- `mem_addr`  out  ADDR_WIDTH  registered memory address.
- `mem_wdata`  out  16  registered memory write data.
- `mem_rdata`  in  16  memory read data, valid the cycle after a read command is driven.

## Operation
- FSM states: IDLE, WIDE2. Reset → IDLE.
- IDLE: if any request, grant one (combinational `*_gnt` same cycle), register its beat-1 command. Wide data grant → WIDE2; otherwise stay IDLE (back-to-back narrow grants every cycle).
- WIDE2: no grants; register beat 2 (address `d_addr+1` mod 2^ADDR_WIDTH, data `d_wdata[31:16]` if write); → IDLE.
- Arbitration: only one requester → it wins. Both → the port not granted most recently wins. After reset, "last granted" = data, so fetch wins the first tie.
- Fetch is always narrow read.
- Read-return tracking: 2-entry tag pipeline (port, beat) aligned to memory latency; responses strictly in issue order.
- Wide read: low word latched from beat-1 return; `d_rdata = {mem_rdata, low_latched}` on beat-2 return.
- Writes produce no `rvalid`.
- Reset (any cycle, including mid-wide or with reads in flight): all outputs to reset values at once, pending returns dropped, no `rvalid` issued for them, FSM → IDLE, tie preference → fetch.
- Reset values: all `*_gnt`, `*_rvalid`, `mem_*` strobes 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` all 0.

## Timing
- Grant in cycle n (IDLE) → beat-1 command on `mem_*` in n+1.
- Narrow read: data on `mem_rdata` in n+2; `rvalid` and `rdata` in n+2. `rdata` is a combinational pass-through for narrow reads.
- Wide: beat 2 in n+2, high data n+3, `d_rvalid` n+3; earliest next grant in n+2.
- Narrow write: memory written at end of n+1. Wide write: low half end of n+1, high half end of n+2.
- Throughput: one narrow access per cycle; wide costs two.
- Strobes deassert in the cycle after the last beat unless a new grant issued.

## Test plan
- Reset, then fetch only, `if_addr`=0x010, mem[0x010]=0xBEEF → `if_gnt` in n, `mem_rd_en`/`mem_addr`=0x010 in n+1, `if_rvalid`/`if_rdata`=0xBEEF in n+2.
- First cycle after reset, both request (narrow data read 0x020), held → fetch granted in n, data in n+1; later continuous ties alternate grants strictly.
- Wide write `d_addr`=0xFFF, `d_wdata`=0x12345678 → mem[0xFFF]=0x5678, mem[0x000]=0x1234; `if_gnt` suppressed in WIDE2.
- Wide read of same words → `d_rvalid` exactly once at n+3 with 0x12345678; no `if_rvalid` in that window.
- Four back-to-back narrow fetches 0x100–0x103 → grants every cycle, four consecutive `if_rvalid` with matching data in order.
- Assert `reset` during WIDE2 with a read in flight → outputs 0 immediately, no `rvalid` afterward, next tie grants fetch.
